dac_pattern_gen: RTL and testbench
==================================

# dac_pattern_gen

Synthesizable multi-channel stimulus generator for the resistor-ladder DAC outputs of the RGB/YPbPr board. It replaces hand-written per-bit PWL stimulus with an on-chip source of ramp, triangle, static, walking-bit and (optionally) pseudo-random codes. Step rate is programmable, and channels are phase-offset copies of one pattern core. It drives the DAC pins directly during bring-up and analog characterisation.

## Interface
- BITS, 4, DAC code width per channel (2..12)
- CHANNELS, 3, number of DAC channels
- PHASE, 0, per-channel code offset; channel k outputs base + k*PHASE mod 2^BITS
- DIV_W, 16, prescaler divisor width

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  run; low freezes prescaler and codes
- restart  in  1  one-cycle pulse; latches mode, reloads start code
- mode  in  3  pattern select, sampled only on restart
- div  in  DIV_W  step period minus one, in clk cycles
- code  in  BITS  static code for STATIC mode, sampled every step
- dac_out  out  CHANNELS*BITS  channel k in bits [k*BITS +: BITS]
- step  out  1  one-cycle pulse coincident with each new dac_out value
- sweep_done  out  1  one-cycle pulse coincident with the last code of a full sweep

## Operation
- Modes: 0 RAMP_UP, 1 RAMP_DOWN, 2 TRIANGLE, 3 STATIC, 4 WALK, 5 PRBS (macro only); 6, 7 and disabled 5 behave as STATIC.
- Prescaler counts 0..div while en=1. Tick when count==div and en=1; count then returns to 0. div=0 gives a tick every cycle.
- On each tick, base advances:
  - RAMP_UP: +1, wrapping max->0.
  - RAMP_DOWN: -1, wrapping 0->max.
  - TRIANGLE: 0..max..0, with a direction flag. Each endpoint is emitted once, so the period is 2*max.
  - STATIC: base=code.
  - WALK: one-hot rotate left; bit BITS-1 goes to bit 0.
- sweep_done on the tick that emits:
  - RAMP_UP: max.
  - RAMP_DOWN: 0.
  - TRIANGLE: 1 on the downward leg.
  - WALK: MSB one-hot.
  - STATIC: never.
  - PRBS: end of the 2^BITS-1 sequence.
- Restart start codes:
  - RAMP_UP, TRIANGLE: 0, direction up.
  - RAMP_DOWN: max.
  - WALK: 1.
  - STATIC: code.
  - PRBS: all-ones seed.
- Restart clears the prescaler and loads dac_out on the next edge; it does not assert step.
- restart beats a coincident tick, and restart works with en=0.
- en=0 holds dac_out and the prescaler. step and sweep_done stay 0.
- div changes take effect immediately. If count > new div, the prescaler keeps counting and wraps at 2^DIV_W, with no forced tick.
- Channel arithmetic is modulo 2^BITS and applied after base, so all channels tick together.

## Timing
- All outputs are registered.
- dac_out updates on the edge where the tick is evaluated; step and sweep_done are high in the following cycle, aligned with the new value.
- Code period is (div+1) clk cycles.
- After restart, the first advance occurs div+1 enabled cycles later.
- Reset values:
  - dac_out = 0, step = 0, sweep_done = 0.
  - Prescaler 0, latched mode RAMP_UP, direction up, base 0.
- Reset asserted mid-sweep returns to these values asynchronously. After release, generation resumes as RAMP_UP from 0 with no restart needed.

## Configuration
- DAC_PATTERN_PRBS_EN defined:
  - Mode 5 is a maximal-length Fibonacci LFSR over BITS bits, seeded all-ones.
  - Code 0 is never emitted.
- DAC_PATTERN_PRBS_EN undefined: LFSR logic is absent and mode 5 decodes as STATIC.

## Structure
- dac_pattern_pkg holds:
  - mode enum and encodings.
  - tap-mask function returning maximal LFSR taps for BITS 2..12.
  - start-code function per mode.
- Sub-module dac_lfsr (BITS parameter; clk, rst, load, advance, state) is instantiated only under DAC_PATTERN_PRBS_EN.
- The top holds the prescaler, pattern core, channel offset adders and output registers.

## Test plan
- rst pulse mid-run with div=2, BITS=4 -> dac_out=0 immediately; after release, codes 1, 2, 3 appear every 3 cycles with step aligned.
- RAMP_UP, div=0, CHANNELS=3, PHASE=5 -> channel words (15,4,9) then (0,5,10); sweep_done with code 15.
- TRIANGLE, div=0 -> 0,1,...,15,14,...,1,0 with 30-cycle period; sweep_done on the downward 1.
- WALK then restart coincident with a tick -> the tick is ignored and dac_out=1; en=0 for 10 cycles freezes all outputs.
- STATIC with code changed 7->9 mid-period -> 9 appears only at the next step; sweep_done never asserts.
- PRBS with macro, BITS=4 -> 15 distinct nonzero codes, then repeat, with sweep_done once per 15 steps; without macro, mode 5 outputs code.

Source files
------------

// File: rtl/dac_pattern_pkg.sv
// Shared types and helpers for the DAC pattern generator: mode encodings, maximal
// LFSR tap masks and per-mode restart codes.
package dac_pattern_pkg;

  localparam int unsigned MaxBits = 12;

  typedef enum logic [2:0] {
    ModeRampUp   = 3'd0,
    ModeRampDown = 3'd1,
    ModeTriangle = 3'd2,
    ModeStatic   = 3'd3,
    ModeWalk     = 3'd4,
    ModePrbs     = 3'd5
  } mode_e;

  // Feedback taps for a left-shifting Fibonacci LFSR; bit i is polynomial term x^(i+1).
  function automatic logic [MaxBits-1:0] lfsr_taps(int unsigned bits);
    case (bits)
      2:       return 12'h003;
      3:       return 12'h006;
      4:       return 12'h00C;
      5:       return 12'h014;
      6:       return 12'h030;
      7:       return 12'h060;
      8:       return 12'h0B8;
      9:       return 12'h110;
      10:      return 12'h240;
      11:      return 12'h500;
      12:      return 12'h829;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [MaxBits-1:0] start_code(mode_e m, logic [MaxBits-1:0] static_code,
                                                    int unsigned bits);
    logic [MaxBits-1:0] max_code;
    max_code = MaxBits'((32'd1 << bits) - 32'd1);
    case (m)
      ModeRampDown: return max_code;
      ModeWalk:     return 12'd1;
      ModeStatic:   return static_code;
      ModePrbs:     return max_code;
      default:      return 12'd0;
    endcase
  endfunction

endpackage

// File: rtl/dac_lfsr.sv
// Maximal-length Fibonacci LFSR for the PRBS pattern. state is the code emitted on the
// next advance; the all-ones seed itself is emitted by the top on restart.
module dac_lfsr
  import dac_pattern_pkg::*;
#(
  parameter int unsigned BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            advance,
  output logic [BITS-1:0] state
);

  localparam logic [BITS-1:0] Taps = BITS'(lfsr_taps(BITS));
  localparam logic [BITS-1:0] Seed = '1;

  function automatic logic [BITS-1:0] lfsr_next(logic [BITS-1:0] s);
    return {s[BITS-2:0], ^(s & Taps)};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= lfsr_next(Seed);
    end else if (load) begin
      state <= lfsr_next(Seed);
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/dac_pattern_gen.sv
// Multi-channel DAC stimulus generator: ramp, triangle, static and walking-bit codes at a
// programmable step rate. Define DAC_PATTERN_PRBS_EN to add the LFSR pattern on mode 5.
module dac_pattern_gen
  import dac_pattern_pkg::*;
#(
  parameter int unsigned BITS     = 4,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned PHASE    = 0,
  parameter int unsigned DIV_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     restart,
  input  logic [2:0]               mode,
  input  logic [DIV_W-1:0]         div,
  input  logic [BITS-1:0]          code,
  output logic [CHANNELS*BITS-1:0] dac_out,
  output logic                     step,
  output logic                     sweep_done
);

  localparam logic [BITS-1:0] One = BITS'(1);
  localparam logic [BITS-1:0] Max = '1;
  localparam logic [BITS-1:0] Msb = One << (BITS - 1);

  logic [DIV_W-1:0] cnt_q;
  mode_e            mode_q;
  logic             dir_up_q;
  logic [BITS-1:0]  base_q;

  logic             tick;
  mode_e            mode_new;
  logic [BITS-1:0]  start_base;
  logic [BITS-1:0]  base_n;
  logic             dir_up_n;
  logic             sweep_n;

  function automatic mode_e decode_mode(logic [2:0] m);
    case (m)
      3'd0:    return ModeRampUp;
      3'd1:    return ModeRampDown;
      3'd2:    return ModeTriangle;
      3'd4:    return ModeWalk;
`ifdef DAC_PATTERN_PRBS_EN
      3'd5:    return ModePrbs;
`endif
      default: return ModeStatic;
    endcase
  endfunction

  // Channels are fixed offsets of the shared base, so they all step together.
  function automatic logic [CHANNELS*BITS-1:0] fan_out(logic [BITS-1:0] b);
    logic [CHANNELS*BITS-1:0] w;
    w = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w[k*BITS +: BITS] = b + BITS'(k * PHASE);
    end
    return w;
  endfunction

  assign tick       = en && (cnt_q == div);
  assign mode_new   = decode_mode(mode);
  assign start_base = BITS'(start_code(mode_new, MaxBits'(code), BITS));

`ifdef DAC_PATTERN_PRBS_EN
  logic [BITS-1:0] lfsr_state;

  dac_lfsr #(
    .BITS(BITS)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (restart && (mode_new == ModePrbs)),
    .advance(!restart && tick && (mode_q == ModePrbs)),
    .state  (lfsr_state)
  );
`endif

  always_comb begin
    base_n   = base_q;
    dir_up_n = dir_up_q;
    sweep_n  = 1'b0;
    case (mode_q)
      ModeRampUp: begin
        base_n  = base_q + One;
        sweep_n = (base_n == Max);
      end
      ModeRampDown: begin
        base_n  = base_q - One;
        sweep_n = (base_n == '0);
      end
      ModeTriangle: begin
        // Direction flips as an endpoint is emitted so each endpoint appears once.
        if (dir_up_q) begin
          base_n = base_q + One;
          if (base_n == Max) dir_up_n = 1'b0;
        end else begin
          base_n = base_q - One;
          if (base_n == '0) dir_up_n = 1'b1;
        end
        sweep_n = !dir_up_q && (base_n == One);
      end
      ModeWalk: begin
        base_n  = {base_q[BITS-2:0], base_q[BITS-1]};
        sweep_n = (base_n == Msb);
      end
`ifdef DAC_PATTERN_PRBS_EN
      ModePrbs: begin
        // The code just before the all-ones seed recurs closes the sequence.
        base_n  = lfsr_state;
        sweep_n = (base_n == (Max >> 1));
      end
`endif
      default: base_n = code;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      mode_q     <= ModeRampUp;
      dir_up_q   <= 1'b1;
      base_q     <= '0;
      dac_out    <= '0;
      step       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      step       <= 1'b0;
      sweep_done <= 1'b0;
      if (restart) begin
        cnt_q    <= '0;
        mode_q   <= mode_new;
        dir_up_q <= 1'b1;
        base_q   <= start_base;
        dac_out  <= fan_out(start_base);
      end else if (tick) begin
        cnt_q      <= '0;
        base_q     <= base_n;
        dir_up_q   <= dir_up_n;
        dac_out    <= fan_out(base_n);
        step       <= 1'b1;
        sweep_done <= sweep_n;
      end else if (en) begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dac_pattern_gen.sv
// Self-checking bench for dac_pattern_gen: directed scenarios with literal expectations,
// then randomized stimulus compared every cycle against a sequence-index reference model.
module tb_dac_pattern_gen;

  localparam int unsigned BITS     = 4;
  localparam int unsigned CHANNELS = 3;
  localparam int unsigned PHASE    = 5;
  localparam int unsigned DIV_W    = 16;
  localparam int          N        = 1 << BITS;

  logic                     clk     = 1'b0;
  logic                     rst     = 1'b1;
  logic                     en      = 1'b0;
  logic                     restart = 1'b0;
  logic [2:0]               mode    = 3'd0;
  logic [DIV_W-1:0]         div     = 16'd2;
  logic [BITS-1:0]          code    = '0;
  logic [CHANNELS*BITS-1:0] dac_out;
  logic                     step;
  logic                     sweep_done;

  int n_cmp  = 0;
  int n_bad  = 0;
  bit chk_on = 1'b0;

  dac_pattern_gen #(
    .BITS    (BITS),
    .CHANNELS(CHANNELS),
    .PHASE   (PHASE),
    .DIV_W   (DIV_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .restart   (restart),
    .mode      (mode),
    .div       (div),
    .code      (code),
    .dac_out   (dac_out),
    .step      (step),
    .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: code as a function of sequence index ----------------
  function automatic int eff_mode(int m);
    if (m <= 4) return m;
`ifdef DAC_PATTERN_PRBS_EN
    if (m == 5) return 5;
`endif
    return 3;
  endfunction

  function automatic int pat_val(int m, int idx, int c);
    int p, t;
    p = 2 * (N - 1);
    case (m)
      0: return idx % N;
      1: return (N - 1) - (idx % N);
      2: begin
        t = idx % p;
        return (t <= N - 1) ? t : p - t;
      end
      4: return 1 << (idx % BITS);
      default: return c;
    endcase
  endfunction

  function automatic logic pat_sweep(int m, int idx);
    case (m)
      0, 1:    return (idx % N) == N - 1;
      2:       return (idx % (2 * (N - 1))) == 2 * (N - 1) - 1;
      4:       return (idx % BITS) == BITS - 1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [CHANNELS*BITS-1:0] fan(int v);
    logic [CHANNELS*BITS-1:0] w;
    w = '0;
    for (int k = 0; k < CHANNELS; k++) w[k*BITS +: BITS] = BITS'((v + k * PHASE) % N);
    return w;
  endfunction

  int                       m_mode  = 0;
  int                       m_idx   = 0;
  int                       m_cnt   = 0;
  logic [CHANNELS*BITS-1:0] m_dac   = '0;
  logic                     m_step  = 1'b0;
  logic                     m_sweep = 1'b0;

  always begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = 0; m_idx = 0; m_cnt = 0; m_dac = '0; m_step = 1'b0; m_sweep = 1'b0;
    end else begin
      m_step  = 1'b0;
      m_sweep = 1'b0;
      if (restart) begin
        m_mode = eff_mode(int'(mode));
        m_idx  = 0;
        m_cnt  = 0;
        m_dac  = fan(pat_val(m_mode, 0, int'(code)));
      end else if (en) begin
        if (m_cnt == int'(div)) begin
          m_cnt   = 0;
          m_idx++;
          m_dac   = fan(pat_val(m_mode, m_idx, int'(code)));
          m_step  = 1'b1;
          m_sweep = pat_sweep(m_mode, m_idx);
        end else begin
          m_cnt = (m_cnt + 1) % (1 << DIV_W);
        end
      end
    end
  end

  always begin
    @(negedge clk);
    if (chk_on) begin
      chk("model_dac_out", 32'(dac_out), 32'(m_dac));
      chk("model_step", 32'(step), 32'(m_step));
      chk("model_sweep_done", 32'(sweep_done), 32'(m_sweep));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic do_restart(int m, int c);
    mode    = 3'(m);
    code    = BITS'(c);
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
  endtask

  task automatic wait_step(output int cycles);
    cycles = 0;
    for (int i = 0; i < 64; i++) begin
      cyc(1);
      cycles++;
      if (step) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL step_timeout: got no step, expected one within 64 cycles at t=%0t", $time);
  endtask

  function automatic int ch0();
    return int'(dac_out[BITS-1:0]);
  endfunction

  int cy;

  initial begin
    cyc(1);
    chk_on = 1'b1;
    cyc(1);
    chk("reset_dac_out", 32'(dac_out), 32'd0);
    chk("reset_step", 32'(step), 32'd0);
    chk("reset_sweep_done", 32'(sweep_done), 32'd0);

    // Reset release resumes RAMP_UP from 0 without a restart.
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wait_step(cy);
      chk("rst_release_gap", 32'(cy), 32'd3);
      chk("rst_release_code", 32'(ch0()), 32'(i));
    end
    cyc(1);
    rst = 1'b1;
    #1;
    chk("async_rst_dac_out", 32'(dac_out), 32'd0);
    cyc(2);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      wait_step(cy);
      chk("rst_midrun_gap", 32'(cy), 32'd3);
      chk("rst_midrun_code", 32'(ch0()), 32'(i));
    end

    // RAMP_UP with phase-offset channels.
    div = 16'd0;
    do_restart(0, 0);
    chk("ramp_start_word", 32'(dac_out), 32'h0A50);
    cyc(15);
    chk("ramp_max_word", 32'(dac_out), 32'h094F);
    chk("ramp_max_sweep", 32'(sweep_done), 32'd1);
    cyc(1);
    chk("ramp_wrap_word", 32'(dac_out), 32'h0A50);
    chk("ramp_wrap_sweep", 32'(sweep_done), 32'd0);

    // TRIANGLE: 0..15..1,0 over 30 steps.
    do_restart(2, 0);
    cyc(15);
    chk("tri_peak", 32'(ch0()), 32'd15);
    cyc(14);
    chk("tri_down_one", 32'(ch0()), 32'd1);
    chk("tri_down_one_sweep", 32'(sweep_done), 32'd1);
    cyc(1);
    chk("tri_floor", 32'(ch0()), 32'd0);
    cyc(30);
    chk("tri_period", 32'(ch0()), 32'd0);

    // WALK, then a restart landing on a tick edge, then a freeze.
    div = 16'd3;
    do_restart(4, 0);
    cyc(4);
    chk("walk_first_step", 32'(ch0()), 32'd2);
    cyc(3);
    do_restart(4, 0);
    chk("walk_restart_beats_tick", 32'(ch0()), 32'd1);
    chk("walk_restart_no_step", 32'(step), 32'd0);
    en = 1'b0;
    cyc(10);
    chk("freeze_dac_out", 32'(dac_out), 32'h0B61);
    chk("freeze_step", 32'(step), 32'd0);
    en = 1'b1;

    // STATIC: a mid-period code change shows only at the next step.
    do_restart(3, 7);
    chk("static_start", 32'(ch0()), 32'd7);
    cyc(1);
    code = BITS'(9);
    cyc(1);
    chk("static_hold", 32'(ch0()), 32'd7);
    cyc(2);
    chk("static_new_code", 32'(ch0()), 32'd9);
    chk("static_step", 32'(step), 32'd1);
    chk("static_no_sweep", 32'(sweep_done), 32'd0);

`ifdef DAC_PATTERN_PRBS_EN
    begin
      bit seen [N];
      int distinct, sweeps;
      int codes [16];
      chk_on = 1'b0;
      div    = 16'd0;
      do_restart(5, 0);
      codes[0] = ch0();
      sweeps   = 0;
      for (int i = 1; i < 16; i++) begin
        cyc(1);
        codes[i] = ch0();
        sweeps += int'(sweep_done);
      end
      distinct = 0;
      for (int i = 0; i < N; i++) seen[i] = 1'b0;
      for (int i = 0; i < 15; i++) begin
        if (codes[i] != 0 && !seen[codes[i]]) distinct++;
        seen[codes[i]] = 1'b1;
      end
      chk("prbs_seed", 32'(codes[0]), 32'(N - 1));
      chk("prbs_distinct_nonzero", 32'(distinct), 32'(N - 1));
      chk("prbs_repeat", 32'(codes[15]), 32'(N - 1));
      chk("prbs_sweeps", 32'(sweeps), 32'd1);
      do_restart(0, 0);
      chk_on = 1'b1;
    end
`else
    div = 16'd1;
    do_restart(5, 6);
    chk("mode5_static_start", 32'(ch0()), 32'd6);
    code = BITS'(11);
    wait_step(cy);
    chk("mode5_static_code", 32'(ch0()), 32'd11);
    chk("mode5_no_sweep", 32'(sweep_done), 32'd0);
`endif

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      int m;
      m = int'($urandom_range(7, 0));
`ifdef DAC_PATTERN_PRBS_EN
      if (m == 5) m = 3;
`endif
      en      = ($urandom_range(5, 0) != 0);
      restart = ($urandom_range(31, 0) == 0);
      mode    = 3'(m);
      code    = BITS'($urandom);
      rst     = ($urandom_range(699, 0) == 0);
      if ($urandom_range(23, 0) == 0) div = DIV_W'($urandom_range(4, 0));
      cyc(1);
    end
    rst     = 1'b0;
    restart = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
